// File: rtl/team_fury_pkg.sv
// Shared definitions for the motor drive path: DIR steering codes, the
// per-wheel channel state, and the DIR-to-wheel command decoder.
// No ports (package).
package team_fury_pkg;

    localparam int unsigned CODE_W = 4;

    // dir[3:2] == 00 is proceed regardless of level[1:0]
    localparam logic [1:0]        DIR_PROCEED  = 2'b00;
    localparam logic [CODE_W-1:0] CODE_VEER_L  = 4'b0101;
    localparam logic [CODE_W-1:0] CODE_PIVOT_L = 4'b0111;
    localparam logic [CODE_W-1:0] CODE_VEER_R  = 4'b1001;
    localparam logic [CODE_W-1:0] CODE_PIVOT_R = 4'b1011;
    localparam logic [CODE_W-1:0] CODE_STOP    = 4'b1111;

    typedef enum logic [1:0] {
        CH_RUN   = 2'd0,
        CH_DECEL = 2'd1,
        CH_DEAD  = 2'd2
    } ch_state_t;

    // Duty magnitudes are parameters of the top, so the decoder only selects
    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_FULL  = 2'd1,
        SEL_VEER  = 2'd2,
        SEL_PIVOT = 2'd3
    } duty_sel_t;

    typedef struct packed {
        logic      halt;     // stop or illegal: brake, zero duty
        logic      illegal;  // undefined code
        logic      l_rev;
        duty_sel_t l_sel;
        logic      r_rev;
        duty_sel_t r_sel;
    } wheel_cmd_t;

    function automatic wheel_cmd_t decode_dir(input logic [CODE_W-1:0] code);
        wheel_cmd_t c;
        c.halt    = 1'b0;
        c.illegal = 1'b0;
        c.l_rev   = 1'b0;
        c.l_sel   = SEL_ZERO;
        c.r_rev   = 1'b0;
        c.r_sel   = SEL_ZERO;
        if (code[3:2] == DIR_PROCEED) begin
            c.l_sel = SEL_FULL;
            c.r_sel = SEL_FULL;
        end else begin
            case (code)
                CODE_VEER_L: begin
                    c.l_sel = SEL_VEER;
                    c.r_sel = SEL_FULL;
                end
                CODE_VEER_R: begin
                    c.l_sel = SEL_FULL;
                    c.r_sel = SEL_VEER;
                end
                CODE_PIVOT_L: begin
                    c.l_rev = 1'b1;
                    c.l_sel = SEL_PIVOT;
                    c.r_sel = SEL_PIVOT;
                end
                CODE_PIVOT_R: begin
                    c.r_rev = 1'b1;
                    c.l_sel = SEL_PIVOT;
                    c.r_sel = SEL_PIVOT;
                end
                CODE_STOP: c.halt = 1'b1;
                default: begin
                    c.halt    = 1'b1;
                    c.illegal = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: duty ramp, reversal FSM (RUN/DECEL/DEAD) with dead-time counter,
// PWM-period-aligned applied duty and the registered pwm/dir pins.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   tick          ramp step strobe
//   wrap          shared PWM counter is at its last count
//   cnt_next      shared PWM counter value for the next cycle
//   halt          accepted command is stop/illegal (level)
//   desired_rev   requested direction (1 = reverse)
//   target        requested duty
//   pwm, dir      registered H-bridge pins
module motor_channel #(
    parameter int unsigned DW          = 12,
    parameter int unsigned RAMP_STEP   = 125,
    parameter int unsigned DEAD_CYCLES = 25000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          wrap,
    input  logic [DW-1:0] cnt_next,
    input  logic          halt,
    input  logic          desired_rev,
    input  logic [DW-1:0] target,
    output logic          pwm,
    output logic          dir
);
    import team_fury_pkg::*;

    localparam int unsigned CW   = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

    ch_state_t     state, state_next;
    logic [DW-1:0] duty, duty_next;
    logic [DW-1:0] applied, applied_next;
    logic [CW-1:0] dead_cnt, dead_next;
    logic          dir_next;
    logic          pwm_next;
    logic          aligned;
    logic [DW-1:0] ramp_tgt;
    logic [DW-1:0] step_gap;

    // State and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CH_RUN;
            duty     <= '0;
            applied  <= '0;
            dead_cnt <= '0;
            dir      <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_next;
            duty     <= duty_next;
            applied  <= applied_next;
            dead_cnt <= dead_next;
            dir      <= dir_next;
            pwm      <= pwm_next;
        end
    end

    // Next state, ramp and applied duty
    always_comb begin
        state_next   = state;
        dead_next    = dead_cnt;
        dir_next     = dir;
        duty_next    = duty;
        applied_next = applied;
        ramp_tgt     = '0;
        step_gap     = '0;
        aligned      = (desired_rev == dir);

        case (state)
            CH_RUN: begin
                if (!halt && !aligned) state_next = CH_DECEL;
            end
            CH_DECEL: begin
                if (halt) begin
                    state_next = CH_DEAD;
                    dead_next  = '0;
                end else if (aligned) begin
                    state_next = CH_RUN;
                end else if (duty == '0) begin
                    state_next = CH_DEAD;
                    dead_next  = '0;
                end
            end
            CH_DEAD: begin
                // Direction only ever changes here, after a full dead window
                if (dead_cnt == CW'(DEAD_CYCLES - 1)) begin
                    state_next = CH_RUN;
                    dead_next  = '0;
                    if (!halt) dir_next = desired_rev;
                end else begin
                    dead_next = dead_cnt + CW'(1);
                end
            end
            default: state_next = CH_RUN;
        endcase

        // Anything but an aligned running wheel ramps toward zero
        if (state == CH_RUN && aligned && !halt) ramp_tgt = target;

        if (halt || state == CH_DEAD) begin
            duty_next = '0;
        end else if (tick) begin
            if (duty < ramp_tgt) begin
                step_gap  = ramp_tgt - duty;
                duty_next = (step_gap > STEP) ? duty + STEP : ramp_tgt;
            end else begin
                step_gap  = duty - ramp_tgt;
                duty_next = (step_gap > STEP) ? duty - STEP : ramp_tgt;
            end
        end

        // Stop and dead time cut the output at once; otherwise load per period
        if (halt || state_next == CH_DEAD) begin
            applied_next = '0;
        end else if (wrap) begin
            applied_next = duty;
        end

        pwm_next = (cnt_next < applied_next);
    end

endmodule

// File: rtl/motor_drive_decoder.sv
// DIR steering code to dual H-bridge drive: input hold filter, command decode,
// shared PWM counter and ramp tick, and one motor_channel per wheel.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   DIR[3:0]       {dir[3:2], level[1:0]} steering code
//   l_pwm, l_dir   left bridge PWM / direction (1 = reverse)
//   r_pwm, r_dir   right bridge PWM / direction (1 = reverse)
//   brake          both bridges braked while stop/illegal is accepted
//   illegal        one-cycle pulse when an undefined code is accepted
module motor_drive_decoder #(
    parameter int unsigned PWM_PERIOD  = 2500,
    parameter int unsigned HOLD_CYCLES = 50000,
    parameter int unsigned RAMP_TICK   = 5000,
    parameter int unsigned RAMP_STEP   = 125,
    parameter int unsigned DEAD_CYCLES = 25000,
    parameter int unsigned DUTY_FULL   = 2500,
    parameter int unsigned DUTY_VEER   = 1250,
    parameter int unsigned DUTY_PIVOT  = 1500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] DIR,
    output logic       l_pwm,
    output logic       l_dir,
    output logic       r_pwm,
    output logic       r_dir,
    output logic       brake,
    output logic       illegal
);
    import team_fury_pkg::*;

    localparam int unsigned DW = $clog2(PWM_PERIOD + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TW = $clog2(RAMP_TICK + 1);

    logic [CODE_W-1:0] dir_q;
    logic [CODE_W-1:0] cmd, cmd_next;
    logic [HW-1:0]     hold_cnt, hold_next;
    logic [DW-1:0]     pwm_cnt, pwm_cnt_next;
    logic [TW-1:0]     tick_cnt, tick_next;
    logic              accept;
    logic              tick;
    logic              wrap;
    wheel_cmd_t        dec;
    logic [DW-1:0]     l_target, r_target;

    function automatic logic [DW-1:0] sel_duty(input duty_sel_t s);
        logic [DW-1:0] d;
        case (s)
            SEL_FULL:  d = DW'(DUTY_FULL);
            SEL_VEER:  d = DW'(DUTY_VEER);
            SEL_PIVOT: d = DW'(DUTY_PIVOT);
            default:   d = '0;
        endcase
        return d;
    endfunction

    // Filter, command, timebase and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q    <= CODE_STOP;
            hold_cnt <= '0;
            cmd      <= CODE_STOP;
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            brake    <= 1'b1;
            illegal  <= 1'b0;
        end else begin
            dir_q    <= DIR;
            hold_cnt <= hold_next;
            cmd      <= cmd_next;
            pwm_cnt  <= pwm_cnt_next;
            tick_cnt <= tick_next;
            brake    <= dec.halt;
            illegal  <= accept & dec.illegal;
        end
    end

    // Hold filter, decode of the command in force after this edge, timebases
    always_comb begin
        hold_next = hold_cnt;
        if (DIR != dir_q) begin
            hold_next = '0;
        end else if (hold_cnt != HW'(HOLD_CYCLES)) begin
            hold_next = hold_cnt + HW'(1);
        end

        // Pin changed HOLD_CYCLES+1 edges ago and stayed put
        accept   = (DIR == dir_q) && (hold_cnt >= HW'(HOLD_CYCLES - 1)) && (dir_q != cmd);
        cmd_next = accept ? dir_q : cmd;

        // Decoding cmd_next lets a same-edge ramp tick see the new target
        dec      = decode_dir(cmd_next);
        l_target = sel_duty(dec.l_sel);
        r_target = sel_duty(dec.r_sel);

        wrap         = (pwm_cnt == DW'(PWM_PERIOD - 1));
        pwm_cnt_next = wrap ? '0 : pwm_cnt + DW'(1);

        tick      = (tick_cnt == TW'(RAMP_TICK - 1));
        tick_next = tick ? '0 : tick_cnt + TW'(1);
    end

    motor_channel #(
        .DW          (DW),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_left (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .wrap        (wrap),
        .cnt_next    (pwm_cnt_next),
        .halt        (dec.halt),
        .desired_rev (dec.l_rev),
        .target      (l_target),
        .pwm         (l_pwm),
        .dir         (l_dir)
    );

    motor_channel #(
        .DW          (DW),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_right (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .wrap        (wrap),
        .cnt_next    (pwm_cnt_next),
        .halt        (dec.halt),
        .desired_rev (dec.r_rev),
        .target      (r_target),
        .pwm         (r_pwm),
        .dir         (r_dir)
    );

endmodule

// File: tb/tb_motor_drive_decoder.sv
// Directed bench for motor_drive_decoder with small timing parameters.
// Edge numbers count rising edges since the last reset release; outputs are
// sampled 2 time units after an edge, inputs change at the same point.
module tb_motor_drive_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] dir_code;
    logic       l_pwm, l_dir, r_pwm, r_dir, brake, illegal;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    motor_drive_decoder #(
        .PWM_PERIOD  (100),
        .HOLD_CYCLES (4),
        .RAMP_TICK   (2),
        .RAMP_STEP   (10),
        .DEAD_CYCLES (5),
        .DUTY_FULL   (100),
        .DUTY_VEER   (50),
        .DUTY_PIVOT  (60)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .DIR     (dir_code),
        .l_pwm   (l_pwm),
        .l_dir   (l_dir),
        .r_pwm   (r_pwm),
        .r_dir   (r_dir),
        .brake   (brake),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic to_edge(input int k);
        while (edge_no < k) begin
            @(posedge clk);
            edge_no++;
        end
        #2;
    endtask

    initial begin
        rst_n    = 1'b0;
        dir_code = 4'b0000;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_brake",   brake,   1'b1);
        chk("reset_l_pwm",   l_pwm,   1'b0);
        chk("reset_r_pwm",   r_pwm,   1'b0);
        chk("reset_l_dir",   l_dir,   1'b0);
        chk("reset_r_dir",   r_dir,   1'b0);
        chk("reset_illegal", illegal, 1'b0);
        rst_n   = 1'b1;
        edge_no = 0;

        // Proceed accepted at edge 5, ramps to 100 by edge 24, applied at wrap 100
        to_edge(4);
        chk("t1_brake_pre", brake, 1'b1);
        chk("t1_lpwm_pre",  l_pwm, 1'b0);
        to_edge(5);
        chk("t1_brake_acc",   brake,   1'b0);
        chk("t1_illegal_acc", illegal, 1'b0);
        to_edge(99);
        chk("t1_lpwm_before_wrap", l_pwm, 1'b0);
        chk("t1_rpwm_before_wrap", r_pwm, 1'b0);
        to_edge(100);
        chk("t1_lpwm_after_wrap", l_pwm, 1'b1);
        chk("t1_rpwm_after_wrap", r_pwm, 1'b1);
        to_edge(190);
        chk("t1_lpwm_full_cnt90", l_pwm, 1'b1);
        chk("t1_rpwm_full_cnt90", r_pwm, 1'b1);

        // Three-cycle veer glitch is never accepted
        dir_code = 4'b0101;
        to_edge(193);
        dir_code = 4'b0000;
        to_edge(196);
        chk("t2_illegal", illegal, 1'b0);
        chk("t2_brake",   brake,   1'b0);
        to_edge(290);
        chk("t2_lpwm_full", l_pwm, 1'b1);
        chk("t2_rpwm_full", r_pwm, 1'b1);

        // Pivot left: accept 295, left decel to 0 at 314, dead 315..320, rev at 320
        dir_code = 4'b0111;
        to_edge(314);
        chk("t3_lpwm_decel", l_pwm, 1'b1);
        chk("t3_ldir_decel", l_dir, 1'b0);
        to_edge(315);
        chk("t3_lpwm_dead_entry", l_pwm, 1'b0);
        to_edge(319);
        chk("t3_ldir_in_dead", l_dir, 1'b0);
        chk("t3_lpwm_in_dead", l_pwm, 1'b0);
        to_edge(320);
        chk("t3_ldir_flipped", l_dir, 1'b1);
        chk("t3_lpwm_exit",    l_pwm, 1'b0);
        to_edge(399);
        chk("t3_lpwm_pre_wrap", l_pwm, 1'b0);
        chk("t3_rpwm_cnt99",    r_pwm, 1'b0);
        to_edge(400);
        chk("t3_lpwm_wrap", l_pwm, 1'b1);
        chk("t3_rpwm_wrap", r_pwm, 1'b1);
        to_edge(459);
        chk("t3_lpwm_cnt59", l_pwm, 1'b1);
        chk("t3_rpwm_cnt59", r_pwm, 1'b1);
        to_edge(460);
        chk("t3_lpwm_cnt60", l_pwm, 1'b0);
        chk("t3_rpwm_cnt60", r_pwm, 1'b0);
        chk("t3_rdir_fwd",   r_dir, 1'b0);

        // Stop (accept 465), re-pivot (accept 492), stop mid-ramp (accept 501)
        dir_code = 4'b1111;
        to_edge(465);
        chk("t4_brake_stop1", brake, 1'b1);
        chk("t4_ldir_kept",   l_dir, 1'b1);
        chk("t4_lpwm_stop1",  l_pwm, 1'b0);
        to_edge(487);
        dir_code = 4'b0111;
        to_edge(492);
        chk("t4_brake_pivot", brake, 1'b0);
        to_edge(496);
        dir_code = 4'b1111;
        to_edge(500);
        chk("t4_lpwm_midramp", l_pwm, 1'b1);
        chk("t4_rpwm_midramp", r_pwm, 1'b1);
        to_edge(501);
        chk("t4_lpwm_killed", l_pwm, 1'b0);
        chk("t4_rpwm_killed", r_pwm, 1'b0);
        chk("t4_brake_stop2", brake, 1'b1);

        // Illegal 0110 accepted at 506, then veer right accepted at 511
        dir_code = 4'b0110;
        to_edge(505);
        chk("t5_illegal_pre",   illegal, 1'b0);
        to_edge(506);
        chk("t5_illegal_pulse", illegal, 1'b1);
        chk("t5_brake_illegal", brake,   1'b1);
        chk("t5_lpwm_illegal",  l_pwm,   1'b0);
        dir_code = 4'b1001;
        to_edge(507);
        chk("t5_illegal_drop", illegal, 1'b0);
        to_edge(510);
        chk("t5_brake_pre_veer", brake, 1'b1);
        to_edge(511);
        chk("t5_brake_veer", brake, 1'b0);
        to_edge(516);
        chk("t5_ldir_dead", l_dir, 1'b1);
        to_edge(517);
        chk("t5_ldir_fwd", l_dir, 1'b0);
        to_edge(599);
        chk("t5_rpwm_pre_wrap", r_pwm, 1'b0);
        to_edge(600);
        chk("t5_rpwm_wrap", r_pwm, 1'b1);
        chk("t5_lpwm_wrap", l_pwm, 1'b1);
        to_edge(649);
        chk("t5_rpwm_cnt49", r_pwm, 1'b1);
        to_edge(650);
        chk("t5_rpwm_cnt50", r_pwm, 1'b0);
        chk("t5_lpwm_cnt50", l_pwm, 1'b1);

        // Pivot left again (accept 705): left dead from 725; reset mid-dead
        to_edge(700);
        dir_code = 4'b0111;
        to_edge(705);
        chk("t6_brake_pivot", brake, 1'b0);
        to_edge(724);
        chk("t6_lpwm_decel", l_pwm, 1'b1);
        to_edge(725);
        chk("t6_lpwm_dead", l_pwm, 1'b0);
        to_edge(727);
        chk("t6_rpwm_before_rst", r_pwm, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_brake",   brake,   1'b1);
        chk("t6_rst_rpwm",    r_pwm,   1'b0);
        chk("t6_rst_lpwm",    l_pwm,   1'b0);
        chk("t6_rst_ldir",    l_dir,   1'b0);
        chk("t6_rst_illegal", illegal, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        edge_no = 0;
        to_edge(4);
        chk("t6_brake_post_pre", brake, 1'b1);
        to_edge(5);
        chk("t6_brake_post_acc", brake, 1'b0);
        to_edge(10);
        chk("t6_ldir_post_dead", l_dir, 1'b0);
        to_edge(11);
        chk("t6_ldir_post_flip", l_dir, 1'b1);
        chk("t6_rdir_post",      r_dir, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
